// File: rtl/xip_cache_pkg.sv
// Shared types and constants for the XIP read cache: FSM states, default
// flash window and index/tag width helpers.
package xip_cache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } xip_state_e;

  localparam logic [31:0] FLASH_BASE_DEF = 32'h3000_0000;
  localparam logic [31:0] FLASH_END_DEF  = 32'h3fff_ffff;
  localparam int          ENTRIES_DEF    = 16;

  function automatic int idx_width(input int entries);
    return $clog2(entries);
  endfunction

  // Word-addressed cache: two byte-offset bits never reach the tag.
  function automatic int tag_width(input int entries);
    return 30 - $clog2(entries);
  endfunction

endpackage

// File: rtl/xip_cache_array.sv
// Direct-mapped valid/tag/data storage: combinational lookup, synchronous
// fill, and a synchronous flush that takes priority over a same-cycle fill.
module xip_cache_array
  import xip_cache_pkg::*;
#(
  parameter  int ENTRIES = ENTRIES_DEF,
  localparam int IDX_W   = idx_width(ENTRIES),
  localparam int TAG_W   = tag_width(ENTRIES)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic [TAG_W-1:0] rd_tag,
  output logic             rd_hit,
  output logic [31:0]      rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [31:0]      wr_data
);

  logic [ENTRIES-1:0] valid_r;
  logic [TAG_W-1:0]   tag_r  [ENTRIES];
  logic [31:0]        data_r [ENTRIES];

  // Lookup port
  always_comb begin
    rd_hit  = valid_r[rd_idx] && (tag_r[rd_idx] == rd_tag);
    rd_data = data_r[rd_idx];
  end

  // Valid bits: reset and flush clear everything, flush beats a fill
  always_ff @(posedge clock) begin
    if (!reset) begin
      valid_r <= '0;
    end else if (flush) begin
      valid_r <= '0;
    end else if (wr_en) begin
      valid_r[wr_idx] <= 1'b1;
    end else begin
      valid_r <= valid_r;
    end
  end

  // Tag/data payload; only meaningful where the valid bit is set
  always_ff @(posedge clock) begin
    if (wr_en) begin
      tag_r[wr_idx]  <= wr_tag;
      data_r[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/xip_read_cache.sv
// Read-only word cache in front of the SPI flash APB bridge.
// Optional hit/miss counters are enabled with XIP_CACHE_PERF_EN.
module xip_read_cache
  import xip_cache_pkg::*;
#(
  parameter logic [31:0] FLASH_BASE = FLASH_BASE_DEF,
  parameter logic [31:0] FLASH_END  = FLASH_END_DEF,
  parameter int          ENTRIES    = ENTRIES_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] in_paddr,
  input  logic        in_psel,
  input  logic        in_penable,
  input  logic [2:0]  in_pprot,
  input  logic        in_pwrite,
  input  logic [31:0] in_pwdata,
  input  logic [3:0]  in_pstrb,
  output logic        in_pready,
  output logic [31:0] in_prdata,
  output logic        in_pslverr,
  output logic [31:0] out_paddr,
  output logic        out_psel,
  output logic        out_penable,
  output logic [2:0]  out_pprot,
  output logic        out_pwrite,
  output logic [31:0] out_pwdata,
  output logic [3:0]  out_pstrb,
  input  logic        out_pready,
  input  logic [31:0] out_prdata,
  input  logic        out_pslverr,
  input  logic        flush
`ifdef XIP_CACHE_PERF_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int IDX_W = idx_width(ENTRIES);
  localparam int TAG_W = tag_width(ENTRIES);

  xip_state_e  state_r, state_nx_s;
  logic [31:0] req_addr_r, req_wdata_r, rsp_data_r;
  logic [3:0]  req_strb_r;
  logic [2:0]  req_prot_r;
  logic        req_write_r, req_fill_r, rsp_err_r;
  logic        access_s, is_flash_s, latch_s, capture_s, wr_en_s;
  logic        rd_hit_s;
  logic [31:0] rd_data_s;

  assign access_s   = in_psel && in_penable;
  assign is_flash_s = (in_paddr >= FLASH_BASE) && (in_paddr <= FLASH_END);
  assign wr_en_s    = capture_s && req_fill_r && !out_pslverr;

  xip_cache_array #(.ENTRIES(ENTRIES)) u_array (
    .clock   (clock),
    .reset   (reset),
    .flush   (flush),
    .rd_idx  (in_paddr[IDX_W+1:2]),
    .rd_tag  (in_paddr[31:IDX_W+2]),
    .rd_hit  (rd_hit_s),
    .rd_data (rd_data_s),
    .wr_en   (wr_en_s),
    .wr_idx  (req_addr_r[IDX_W+1:2]),
    .wr_tag  (req_addr_r[31:IDX_W+2]),
    .wr_data (out_prdata)
  );

  // Next state and all APB outputs; everything reads as zero while in reset
  always_comb begin
    state_nx_s  = state_r;
    latch_s     = 1'b0;
    capture_s   = 1'b0;
    in_pready   = 1'b0;
    in_prdata   = 32'h0000_0000;
    in_pslverr  = 1'b0;
    out_paddr   = 32'h0000_0000;
    out_psel    = 1'b0;
    out_penable = 1'b0;
    out_pprot   = 3'b000;
    out_pwrite  = 1'b0;
    out_pwdata  = 32'h0000_0000;
    out_pstrb   = 4'b0000;
    if (!reset) begin
      state_nx_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (!access_s) begin
            state_nx_s = ST_IDLE;
          end else if (is_flash_s && in_pwrite) begin
            in_pready  = 1'b1;
            in_pslverr = 1'b1;
          end else if (is_flash_s && rd_hit_s) begin
            in_pready = 1'b1;
            in_prdata = rd_data_s;
          end else begin
            latch_s    = 1'b1;
            state_nx_s = ST_SETUP;
          end
        end
        ST_SETUP, ST_ACCESS: begin
          out_psel    = 1'b1;
          out_penable = (state_r == ST_ACCESS);
          out_paddr   = req_addr_r;
          out_pprot   = req_prot_r;
          out_pwrite  = req_write_r;
          out_pwdata  = req_wdata_r;
          out_pstrb   = req_strb_r;
          if (state_r == ST_SETUP) begin
            state_nx_s = ST_ACCESS;
          end else if (out_pready) begin
            capture_s  = 1'b1;
            state_nx_s = ST_RESP;
          end else begin
            state_nx_s = ST_ACCESS;
          end
        end
        ST_RESP: begin
          in_pready  = 1'b1;
          in_prdata  = rsp_data_r;
          in_pslverr = rsp_err_r;
          state_nx_s = ST_IDLE;
        end
        default: begin
          state_nx_s = ST_IDLE;
        end
      endcase
    end
  end

  // State, latched downstream request and captured response
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      req_addr_r  <= 32'h0000_0000;
      req_wdata_r <= 32'h0000_0000;
      req_strb_r  <= 4'b0000;
      req_prot_r  <= 3'b000;
      req_write_r <= 1'b0;
      req_fill_r  <= 1'b0;
      rsp_data_r  <= 32'h0000_0000;
      rsp_err_r   <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      if (latch_s) begin
        req_prot_r <= in_pprot;
        // A flash miss becomes a plain aligned word read
        if (is_flash_s) begin
          req_addr_r  <= {in_paddr[31:2], 2'b00};
          req_wdata_r <= 32'h0000_0000;
          req_strb_r  <= 4'b0000;
          req_write_r <= 1'b0;
          req_fill_r  <= 1'b1;
        end else begin
          req_addr_r  <= in_paddr;
          req_wdata_r <= in_pwdata;
          req_strb_r  <= in_pstrb;
          req_write_r <= in_pwrite;
          req_fill_r  <= 1'b0;
        end
      end
      if (capture_s) begin
        rsp_data_r <= out_prdata;
        rsp_err_r  <= out_pslverr;
      end
    end
  end

`ifdef XIP_CACHE_PERF_EN
  logic hit_ev_s, miss_ev_s;

  assign hit_ev_s  = reset && (state_r == ST_IDLE) && access_s && is_flash_s &&
                     !in_pwrite && rd_hit_s;
  assign miss_ev_s = reset && (state_r == ST_IDLE) && access_s && is_flash_s &&
                     !in_pwrite && !rd_hit_s;

  // Free-running hit/miss counters, cleared by reset only
  always_ff @(posedge clock) begin
    if (!reset) begin
      hit_cnt  <= 32'h0000_0000;
      miss_cnt <= 32'h0000_0000;
    end else begin
      hit_cnt  <= hit_ev_s  ? hit_cnt + 32'd1  : hit_cnt;
      miss_cnt <= miss_ev_s ? miss_cnt + 32'd1 : miss_cnt;
    end
  end
`endif

endmodule

// File: doc/xip_read_cache.md
# xip_read_cache

Direct-mapped, read-only word cache between the CPU-side APB fabric and the SPI flash APB bridge. Flash-region reads that hit return in zero wait states. Misses and all non-flash traffic are forwarded unchanged to the downstream APB port, so the slow SPI XIP sequence (command, divider, SS, GO, poll, read) runs only once per cached word.

## Interface
- `FLASH_BASE`, 32'h30000000: first byte address of the cacheable flash window.
- `FLASH_END`, 32'h3fffffff: last byte address of the window, inclusive.
- `ENTRIES`, 16: number of cached 32-bit words; must be a power of 2, from 2 to 256.

- `clock` in 1: single clock for the block; all state changes on its rising edge.
- `reset` in 1: synchronous, active-low; the block resets on a rising edge while `reset` is 0.
- `in_paddr` in 32, `in_psel` in 1, `in_penable` in 1, `in_pprot` in 3, `in_pwrite` in 1, `in_pwdata` in 32, `in_pstrb` in 4: upstream APB request.
- `in_pready` out 1, `in_prdata` out 32, `in_pslverr` out 1: upstream APB response.
- `out_paddr` out 32, `out_psel` out 1, `out_penable` out 1, `out_pprot` out 3, `out_pwrite` out 1, `out_pwdata` out 32, `out_pstrb` out 4: downstream APB request to the SPI bridge.
- `out_pready` in 1, `out_prdata` in 32, `out_pslverr` in 1: downstream APB response.
- `flush` in 1: single-cycle pulse that invalidates every entry.
- `hit_cnt` out 32, `miss_cnt` out 32: present only with `XIP_CACHE_PERF_EN` (see Configuration).

## Operation
- **Address decode**
  - Flash = `FLASH_BASE <= in_paddr <= FLASH_END`.
  - IDX = log2(`ENTRIES`); index = `in_paddr[IDX+1:2]`; tag = `in_paddr[31:IDX+2]`.
  - Byte offset is ignored: the full word is returned.
- **Each entry** holds valid (1 bit), tag, and data (32 bits).
- **States:** IDLE, SETUP, ACCESS, RESP.
- **IDLE**, on an access phase (`in_psel & in_penable`):
  - Flash read, hit: `in_pready`=1 and `in_prdata`=entry data combinationally in the same cycle; stay in IDLE.
  - Flash write: `in_pready`=1 and `in_pslverr`=1 the same cycle; nothing forwarded; cache unchanged.
  - Flash read, miss: latch request; go to SETUP. The forwarded address is word-aligned (`{in_paddr[31:2],2'b00}`), `pstrb` is 0 and `pwrite` is 0.
  - Non-flash (read or write): latch request; go to SETUP. Address, strobe and wdata are forwarded unmodified.
- **SETUP:** `out_psel`=1, `out_penable`=0; go to ACCESS.
- **ACCESS:** `out_psel`=1, `out_penable`=1; hold until `out_pready`=1.
  - Then capture `out_prdata` and `out_pslverr`.
  - For a flash miss with no error, write the entry (valid=1, tag, data).
  - Go to RESP.
- **RESP:** `in_pready`=1 with the captured data and `pslverr` for exactly one cycle; go to IDLE.
- **Idle outputs:** `in_pready`, `in_pslverr` and all `out_*` are 0 outside the cases above; `in_prdata` is 0 when `in_pready`=0.
- **Error on fill:** a downstream `pslverr` on a flash miss is propagated upstream; the entry is not filled, and any previous contents of that entry stay unchanged.
- **Flush:**
  - Clears all valid bits at the next edge.
  - If `flush` coincides with an ACCESS-state fill, flush wins and the entry stays invalid; the read data is still returned in RESP.
  - If `flush` is sampled in the same cycle as a hit, that hit still completes with the old data.
- **Mid-transfer drop:** once SETUP is entered, the downstream transfer always completes, even if upstream drops `in_psel`. RESP is still driven for one cycle, then the block returns to IDLE.

## Timing
- Reset:
  - State = IDLE.
  - All valid bits = 0.
  - All outputs = 0.
  - Counters = 0.
- Reset asserted mid-transfer aborts immediately; downstream `psel` and `penable` drop at that edge.
- Hit: 0 wait states (`in_pready` in the first access-phase cycle).
- Miss or pass-through, with access phase first seen at cycle 0:
  - cycle 1 = SETUP, cycle 2 = ACCESS.
  - If `out_pready` is seen at cycle 2+k, RESP is at cycle 3+k.
  - Upstream wait states = 3+k.
- Back-to-back: a new access phase can be accepted the cycle after RESP.

## Configuration
- `XIP_CACHE_PERF_EN` defined:
  - `hit_cnt` and `miss_cnt` ports exist.
  - `hit_cnt` increments on each flash-read hit.
  - `miss_cnt` increments on each flash-read miss at the IDLE→SETUP edge.
  - Both counters wrap modulo 2^32 and are cleared by reset only.
- `XIP_CACHE_PERF_EN` undefined: neither the ports nor the counter logic exist; all other behaviour is identical.

## Structure
- Package `xip_cache_pkg` holds:
  - the state enum (IDLE, SETUP, ACCESS, RESP);
  - the default window constants;
  - a function for the IDX/tag widths.
- Sub-module `xip_cache_array` holds the valid/tag/data storage:
  - one combinational read port returning hit and data;
  - one synchronous write port;
  - a synchronous flush, with flush priority over write.

## Test plan
- Read 0x30000004 after reset: downstream sees one SETUP/ACCESS with `paddr`=0x30000004, `pstrb`=0. With `out_pready` after 2 waits and data 0xDEADBEEF, upstream gets 0xDEADBEEF with 5 wait states; a repeat read returns 0xDEADBEEF with 0 waits and no downstream activity.
- Read 0x30000006, then 0x30000046 (`ENTRIES`=16, same index, different tag): both miss, the second evicts the first, and a re-read of 0x30000004 misses again.
- Write to 0x30000000: `in_pready`=1 and `pslverr`=1 in the same cycle; no downstream `psel`.
- Read then write 0x10001010 with `pstrb`=4'b0011: both are forwarded unmodified with 3 wait states and never cached.
- Fill 0x30000008 with `pslverr`=1 from downstream: upstream `pslverr`=1, and the next read of 0x30000008 misses. Then pulse `flush` during a fill's ACCESS cycle: the data is returned but the next read misses.
- With `XIP_CACHE_PERF_EN`: 3 misses and 5 hits give `miss_cnt`=3 and `hit_cnt`=5. Asserting reset low mid-ACCESS zeroes all outputs and counters at the next edge.
